// File: rtl/seg_scan_drv_if.sv
// Bundles the ring-counter phase, display data and fault controls with the
// anode/segment drive and status outputs of the seven-segment scan driver.
interface seg_scan_drv_if;
  logic [3:0]  phase;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        data_we;
  logic        fault_clr;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        seg_dp;
  logic        frame_tick;
  logic        fault;
  logic [7:0]  fault_cnt;

  modport master (
    output phase, data, dp, data_we, fault_clr,
    input  an, seg, seg_dp, frame_tick, fault, fault_cnt
  );

  modport slave (
    input  phase, data, dp, data_we, fault_clr,
    output an, seg, seg_dp, frame_tick, fault, fault_cnt
  );
endinterface

// File: rtl/seg_scan_drv.sv
// Four-digit multiplexed seven-segment scan driver slaved to a one-hot ring
// counter, with dead-time blanking, frame-synchronous data update and ring checking.
module seg_scan_drv #(
  parameter int unsigned BLANK_CYC    = 4,
  parameter bit          COMMON_ANODE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  seg_scan_drv_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE,
    ST_FAULT
  } state_t;

  localparam logic [3:0] BLK_LOAD = 4'(BLANK_CYC - 1);
  localparam logic [3:0] AN_DARK  = COMMON_ANODE ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_DARK = COMMON_ANODE ? 7'h7F : 7'h00;
  localparam logic       DP_DARK  = COMMON_ANODE;

  state_t      state_q, state_d;
  logic [3:0]  phase_q, prev_q, blk_cnt_q, blk_cnt_d;
  logic [15:0] pend_data_q, pend_data_d, disp_data_q, disp_data_d;
  logic [3:0]  pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic        pend_q, pend_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        seg_dp_q, seg_dp_d;
  logic        frame_tick_q, frame_tick_d;
  logic        fault_q, fault_d;
  logic [7:0]  fault_cnt_q, fault_cnt_d;

  logic        multi, onehot, prev_onehot, changed, running;
  logic        bad_seq, fault_cond, fault_entry, frame;
  logic [3:0]  nib;
  logic        dp_sel;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d   = state_q;
    blk_cnt_d = blk_cnt_q;

    multi       = (phase_q & (phase_q - 4'd1)) != '0;
    onehot      = (phase_q != '0) && !multi;
    prev_onehot = (prev_q != '0) && ((prev_q & (prev_q - 4'd1)) == '0);
    changed     = phase_q != prev_q;
    running     = (state_q == ST_BLANK) || (state_q == ST_DRIVE);
    bad_seq     = running && changed && onehot && prev_onehot &&
                  (phase_q != {prev_q[2:0], prev_q[3]});
    // A held multi-bit value in FAULT is a hold, not a fresh entry.
    fault_cond  = (multi && (state_q != ST_FAULT)) || bad_seq;

    if (fault_cond) begin
      state_d = ST_FAULT;
    end else if (phase_q == '0) begin
      state_d = ST_IDLE;
    end else if (!running) begin
      if (onehot) begin
        state_d   = ST_BLANK;
        blk_cnt_d = BLK_LOAD;
      end
    end else if (changed) begin
      state_d   = ST_BLANK;
      blk_cnt_d = BLK_LOAD;
    end else if (state_q == ST_BLANK) begin
      if (blk_cnt_q == '0) state_d = ST_DRIVE;
      else                 blk_cnt_d = blk_cnt_q - 4'd1;
    end

    fault_entry = (state_d == ST_FAULT) && (state_q != ST_FAULT);
    fault_d     = fault_q;
    fault_cnt_d = fault_cnt_q;
    if (fault_entry) begin
      fault_d     = 1'b1;
      fault_cnt_d = bus.fault_clr ? 8'd1 :
                    ((fault_cnt_q == 8'hFF) ? fault_cnt_q : fault_cnt_q + 8'd1);
    end else if (bus.fault_clr) begin
      fault_d     = 1'b0;
      fault_cnt_d = '0;
    end

    frame        = (phase_q == 4'b0001) && changed && (state_d != ST_FAULT);
    frame_tick_d = frame && (prev_q == 4'b1000);

    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_d      = pend_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    if (frame && pend_q) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      pend_d      = 1'b0;
    end
    if (bus.data_we) begin
      pend_data_d = bus.data;
      pend_dp_d   = bus.dp;
      pend_d      = 1'b1;
    end

    nib    = '0;
    dp_sel = 1'b0;
    case (phase_q)
      4'b0001: begin nib = disp_data_d[3:0];   dp_sel = disp_dp_d[0]; end
      4'b0010: begin nib = disp_data_d[7:4];   dp_sel = disp_dp_d[1]; end
      4'b0100: begin nib = disp_data_d[11:8];  dp_sel = disp_dp_d[2]; end
      4'b1000: begin nib = disp_data_d[15:12]; dp_sel = disp_dp_d[3]; end
      default: begin nib = '0;                 dp_sel = 1'b0;         end
    endcase

    an_d     = AN_DARK;
    seg_d    = SEG_DARK;
    seg_dp_d = DP_DARK;
    if (state_d == ST_DRIVE) begin
      an_d     = COMMON_ANODE ? ~phase_q    : phase_q;
      seg_d    = COMMON_ANODE ? ~hex7(nib)  : hex7(nib);
      seg_dp_d = COMMON_ANODE ? ~dp_sel     : dp_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      prev_q       <= '0;
      blk_cnt_q    <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_q       <= 1'b0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      an_q         <= AN_DARK;
      seg_q        <= SEG_DARK;
      seg_dp_q     <= DP_DARK;
      frame_tick_q <= 1'b0;
      fault_q      <= 1'b0;
      fault_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= bus.phase;
      prev_q       <= phase_q;
      blk_cnt_q    <= blk_cnt_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_q       <= pend_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      frame_tick_q <= frame_tick_d;
      fault_q      <= fault_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.seg_dp     = seg_dp_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.fault      = fault_q;
  assign bus.fault_cnt  = fault_cnt_q;

endmodule

// File: doc/seg_scan_drv.md
# seg_scan_drv

Four-digit multiplexed seven-segment scan driver that sits directly downstream of the 4-bit one-hot ring counter and consumes its rotating phase as the digit select. For each phase it drives the selected anode and hex-decoded segments, with dead-time blanking against ghosting. Display data is updated only at frame boundaries. The block also checks that the ring sequence is legal and records faults.

## Interface
- BLANK_CYC, 4, dark cycles after every phase change before driving; must be ≥1
- COMMON_ANODE, 1, 1 = an/seg/seg_dp active-low; 0 = active-high
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- phase  in  4  ring counter output, synchronous to clk; bit i selects digit i
- data  in  16  four hex nibbles; digit i = data[4i+3:4i]
- dp  in  4  decimal point per digit
- data_we  in  1  capture data/dp into pending register
- fault_clr  in  1  clear fault and fault_cnt
- an  out  4  anode drive
- seg  out  7  segments {g,f,e,d,c,b,a}
- seg_dp  out  1  decimal-point segment
- frame_tick  out  1  one-cycle pulse at frame boundary
- fault  out  1  sticky sequence fault
- fault_cnt  out  8  saturating count of fault entries

## Operation
- phase_q: phase registered every cycle. All decisions use phase_q.
- Legal successor of phase_q: 0001→0010→0100→1000→0001.
- Value 0000 is the ring counter's reset state. It is treated as IDLE, not as a fault.
- States:
  - IDLE: outputs dark.
  - BLANK: outputs dark; counter blk_cnt runs.
  - DRIVE: an = phase_q (polarity-adjusted); seg/seg_dp = decoded nibble/dp of the selected digit.
  - FAULT: outputs dark.
- Fault condition: phase_q has ≥2 bits set, OR phase_q changes from one one-hot value to a one-hot value that is not its successor.
  - This check is applied in BLANK and DRIVE.
  - From IDLE or FAULT, any one-hot value is accepted.
- Transitions, in priority order:
  - Fault condition → FAULT.
  - phase_q == 0000 → IDLE.
  - IDLE/FAULT with one-hot phase_q → BLANK, blk_cnt = BLANK_CYC-1.
  - BLANK/DRIVE with a legal phase_q change → BLANK, blk_cnt = BLANK_CYC-1. Blanking restarts on every change.
  - BLANK with blk_cnt == 0 → DRIVE; otherwise blk_cnt decrements.
  - FAULT holds while phase_q has ≥2 bits set.
- fault and fault_cnt:
  - On each entry into FAULT (not while held): fault ← 1, fault_cnt increments, saturating at 255.
  - fault_clr clears both. If a fault entry occurs in the same cycle, the entry wins: fault = 1, fault_cnt = 1.
  - fault is otherwise cleared only by reset.
- Data path:
  - data_we loads pend_data/pend_dp and sets pend.
  - Frame boundary: phase_q becomes 0001 from any other value while not entering FAULT.
  - At a frame boundary with pend = 1: disp ← pending and pend clears. If data_we is also high that cycle, pending takes the new value and pend stays 1; that value shows next frame.
  - frame_tick pulses only for the legal transition 1000→0001.
- Decode, active-high patterns (inverted when COMMON_ANODE = 1):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Dark: an, seg and seg_dp all at their inactive level. With COMMON_ANODE = 1 that is 1111 / 7F / 1.
- Phase held for fewer than BLANK_CYC+1 cycles: the display stays dark. This is not a fault.

## Timing
- Reset (asynchronous, immediate on rst low):
  - state IDLE; phase_q, disp, pending, pend, blk_cnt = 0.
  - an, seg, seg_dp dark; frame_tick = 0; fault = 0; fault_cnt = 0.
- All outputs are registered and computed from next-state, so they update on the same edge as the state.
- A phase input change sampled at edge E0 gives: dark from E1, DRIVE at E1+BLANK_CYC. That is BLANK_CYC dark cycles per digit.
- frame_tick and the disp load occur at edge E1 after 0001 is sampled. Digit 0 shows the new data BLANK_CYC cycles later.
- A fault is visible (fault = 1, outputs dark) at E1 after the illegal value is sampled.
- rst low mid-DRIVE: outputs go dark asynchronously; pending data is lost.

## Test plan
- Reset: drive phase 0001 into DRIVE, pulse rst low → an = 1111, seg = 7F, seg_dp = 1 with no clock edge; fault = 0, fault_cnt = 0.
- Scan (BLANK_CYC = 4, COMMON_ANODE = 1): write data = 16'h1234, dp = 0 in IDLE, then phase 0001, 0010, 0100, 1000, each held 8 cycles.
  - Each digit is dark for 4 cycles, then an = 1110 / seg = 19, an = 1101 / seg = 30, an = 1011 / seg = 24, an = 0111 / seg = 79.
- Frame load: write 16'hABCD while phase = 0100 → digits 2 and 3 still show 2 and 1; on 1000→0001, frame_tick is high for 1 cycle and digit 0 then shows seg = 21.
- Faults:
  - phase 0011 held 5 cycles → fault = 1, fault_cnt = 1, dark throughout.
  - Recover with 0001, then skip to 0100 → fault_cnt = 2.
  - fault_clr together with a new 0110 → fault = 1, fault_cnt = 1.
  - 300 fault entries → fault_cnt = 255.
- Fast ring: phase rotates legally every 2 cycles with BLANK_CYC = 4 → an stays 1111 and fault stays 0.
